// File: rtl/vga_timing_gen.sv
// Raster timing generator: 10-bit pixel/line counters whose decode (position, blank,
// sync levels, line/frame strobes, frame counter) is registered one enabled cycle later.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_hc, r_vc;
  logic [9:0] r_drawx, r_drawy;
  logic       r_hs, r_vs, r_blank, r_line_start, r_frame_start;
  logic [7:0] r_frame_count;

  logic [9:0] w_hc_nxt, w_vc_nxt;
  logic       w_hs, w_vs, w_blank, w_line_start, w_frame_start;

  // Next counter position and decode of the position currently held.
  always_comb begin
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    if (r_hc == H_LAST) begin
      w_hc_nxt = 10'd0;
      if (r_vc == V_LAST) begin
        w_vc_nxt = 10'd0;
      end else begin
        w_vc_nxt = r_vc + 10'd1;
      end
    end else begin
      w_hc_nxt = r_hc + 10'd1;
    end

    w_blank       = (r_hc < H_VIS_END) && (r_vc < V_VIS_END);
    // vs depends on the line only, so it covers the horizontal blanking of sync lines too
    w_hs          = ((r_hc >= HS_START) && (r_hc < HS_END)) ? HS_POL : ~HS_POL;
    w_vs          = ((r_vc >= VS_START) && (r_vc < VS_END)) ? VS_POL : ~VS_POL;
    w_line_start  = (r_hc == 10'd0);
    w_frame_start = (r_hc == 10'd0) && (r_vc == 10'd0);
  end

  // Counters and output registers; strobes drop on idle cycles so they stay one clock wide.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_drawx       <= 10'd0;
      r_drawy       <= 10'd0;
      r_blank       <= 1'b0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else if (pix_en) begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_drawx       <= r_hc;
      r_drawy       <= r_vc;
      r_blank       <= w_blank;
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_frame_count <= r_frame_count;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign DrawX       = r_drawx;
  assign DrawY       = r_drawy;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the raster scan that every sprite and board renderer consumes: DrawX/DrawY pixel coordinates, the active-video flag `blank`, and hs/vs sync pulses for the VGA connector. Default timing is 640x480 at 60 Hz. It is the upstream end of the DrawX/DrawY/blank interface, and renderers register their pixel colour on the same vga_clk. It also provides line-start and frame-start strobes plus a free-running frame counter, used for cursor blink and move-animation timing.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hs (0 = active-low)
VS_POL, 0, asserted level of vs (0 = active-low)
Constraint: H_TOTAL = sum of the four H_* values and V_TOTAL = sum of the four V_* values; each total must be <= 1024.

Ports:
vga_clk  input  1  pixel-domain clock
reset  input  1  synchronous, active-high reset
pix_en  input  1  pixel advance enable; counters and outputs move only on cycles where it is high
hs  output  1  horizontal sync, level set by HS_POL
vs  output  1  vertical sync, level set by VS_POL
blank  output  1  1 = visible region (draw), 0 = blanking
DrawX  output  10  current horizontal position, 0..H_TOTAL-1
DrawY  output  10  current vertical position, 0..V_TOTAL-1
line_start  output  1  one-clock strobe when DrawX becomes 0
frame_start  output  1  one-clock strobe when (DrawX, DrawY) becomes (0,0)
frame_count  output  8  frame counter, wraps 255 -> 0

Behaviour:
- Internal state: 10-bit counters hc and vc, both 0 at reset.
- Enabled cycle (pix_en=1, reset=0), at the clock edge:
  - Output registers load the decode of the current (hc, vc).
  - The counter then advances: hc+1; at H_TOTAL-1, hc wraps to 0 and vc increments; at V_TOTAL-1 with hc=H_TOTAL-1, vc wraps to 0.
- Latency: outputs show the position held by the counter on the previous enabled cycle. The first enabled cycle after reset produces DrawX=0, DrawY=0 at the following edge.
- Decode rules for a loaded position (hc, vc):
  - DrawX = hc, DrawY = vc.
  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - hs is asserted iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC; otherwise it is at the deasserted level.
  - vs is asserted iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, and it is evaluated per line, so vs spans whole lines including their horizontal blanking.
  - line_start = (hc == 0); frame_start = (hc == 0 && vc == 0).
  - frame_count increments by 1 (mod 256) at the same edge that frame_start is set.
- Disabled cycle (pix_en=0): hc, vc, DrawX, DrawY, hs, vs, blank and frame_count all hold. line_start and frame_start are cleared to 0, so each strobe is exactly one vga_clk wide regardless of pix_en duty.
- Reset, including mid-frame, takes priority over pix_en. At the next edge:
  - hc=0, vc=0, DrawX=0, DrawY=0, frame_count=0.
  - blank=0, line_start=0, frame_start=0.
  - hs=~HS_POL and vs=~VS_POL (both deasserted).
- No glitches: every output comes directly from a flop.
- Arithmetic: all comparisons are unsigned 10-bit. Sync and porch bounds are computed from the parameters at elaboration time.

Test Plan:
- Reset, then pix_en=1 constantly for 420000 cycles (defaults):
  - DrawX sweeps 0..799 and DrawY sweeps 0..524, each exactly once per frame.
  - frame_start pulses at cycle 1 and cycle 420001; frame_count goes 1 -> 2.
  - blank=1 for exactly 307200 cycles per frame.
- Horizontal sync check:
  - hs=0 for exactly 96 consecutive outputs, at DrawX=656..751 on every line.
  - blank=0 at DrawX=640..799.
  - line_start=1 only when DrawX=0.
- Vertical sync check: vs=0 for exactly 1600 consecutive enabled outputs, at DrawY=490..491, and is high otherwise.
- pix_en toggled 1,0,1,0:
  - Positions advance on every other clock, and one frame takes 840000 clocks.
  - frame_start and line_start are high for 1 clock only, never 2.
- Reset asserted for 1 cycle at DrawX=300, DrawY=200:
  - Next edge gives DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_count=0.
  - The next enabled output is (0,0) with blank=1 and frame_start=1.
- frame_count wrap: run 256 frames after reset (pix_en=1); frame_count reads 255 -> 0 at the 256th frame_start, with no other output disturbed.
